// File: rtl/mux21_arb_pkg.sv
// mux21_arb_pkg: shared types and helpers for the 2:1 mux round-robin arbiter.
// Build option: MUX21_ARB_HOLD_LIMIT_EN enables hold-limit preemption.
package mux21_arb_pkg;

  // Number of requesters sharing the mux path.
  localparam int ARB_REQ_N = 2;

  // Arbiter FSM encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Width of a counter that must hold the value max_hold.
  function automatic int hold_w(input int max_hold);
    return $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/mux21_arb_if.sv
// mux21_arb_if: request/grant/select bundle between requesters and the arbiter.
// Build option: MUX21_ARB_HOLD_LIMIT_EN (no effect on this interface).
interface mux21_arb_if;
  logic req0;
  logic req1;
  logic gnt0;
  logic gnt1;
  logic s;
  logic busy;

  // Requester side: raises requests, watches grants and select.
  modport master (
    output req0, req1,
    input  gnt0, gnt1, s, busy
  );

  // Arbiter side: samples requests, drives grants and select.
  modport slave (
    input  req0, req1,
    output gnt0, gnt1, s, busy
  );
endinterface

// File: rtl/mux21_hold_cnt.sv
// mux21_hold_cnt: saturating tenure counter for the current grant owner.
// Used only when MUX21_ARB_HOLD_LIMIT_EN is defined.
module mux21_hold_cnt
  import mux21_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  localparam int HOLD_W  = hold_w(MAX_HOLD)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  output logic              expire,
  output logic [HOLD_W-1:0] cnt
);

  localparam logic [HOLD_W-1:0] CNT_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] CNT_EXP = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] r_cnt;

  // Clear on grant change, otherwise count owner cycles and stick at MAX_HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_cnt <= '0;
    else if (clr)                  r_cnt <= '0;
    else if (en && r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
  end

  // Expiry stays asserted once saturated so a late contender preempts at once.
  assign expire = (r_cnt >= CNT_EXP);
  assign cnt    = r_cnt;

endmodule

// File: rtl/mux21_arb.sv
// mux21_arb: round-robin owner of the 2:1 mux select line.
// Build option: MUX21_ARB_HOLD_LIMIT_EN bounds tenure to MAX_HOLD cycles
// while the other requester waits; without it the owner holds until release.
module mux21_arb
  import mux21_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  mux21_arb_if.slave  bus
);

  // Legal MAX_HOLD is 1..255; an out-of-range value leaves this marker block
  // in the elaborated hierarchy.
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_out_of_range
  end

  arb_state_t r_state;
  arb_state_t w_nxt;
  logic       r_s;
  logic       r_last;
  logic       w_expire;
  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_req0;
  logic       w_req1;

  assign w_req0 = bus.req0;
  assign w_req1 = bus.req1;

`ifdef MUX21_ARB_HOLD_LIMIT_EN
  localparam int HOLD_W = hold_w(MAX_HOLD);

  logic [HOLD_W-1:0] w_hold_cnt;
  logic              w_hold_clr;
  logic              w_hold_en;

  // Tenure restarts whenever ownership changes, including drops to IDLE.
  assign w_hold_clr = (w_nxt != r_state);
  assign w_hold_en  = (r_state != IDLE);

  mux21_hold_cnt #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (w_hold_clr),
    .en     (w_hold_en),
    .expire (w_expire),
    .cnt    (w_hold_cnt)
  );

  // Count value is only needed for debug visibility; expiry drives the FSM.
  logic w_hold_cnt_unused;
  assign w_hold_cnt_unused = ^w_hold_cnt;
`else
  // Without the hold limit the owner is never preempted.
  assign w_expire = 1'b0;
`endif

  // Next owner: release hands over directly, contention alternates on last.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_req0 && w_req1) w_nxt = r_last ? OWN0 : OWN1;
        else if (w_req0)      w_nxt = OWN0;
        else if (w_req1)      w_nxt = OWN1;
      end
      OWN0: begin
        if (!w_req0)                w_nxt = w_req1 ? OWN1 : IDLE;
        else if (w_expire && w_req1) w_nxt = OWN1;
      end
      OWN1: begin
        if (!w_req1)                w_nxt = w_req0 ? OWN0 : IDLE;
        else if (w_expire && w_req0) w_nxt = OWN0;
      end
      default: w_nxt = IDLE;
    endcase
  end

  // Ownership state; reset drops any grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  // Select and last-owner follow each grant and hold through IDLE so the mux
  // output never flips while nobody owns it. last=1 lets requester 0 win first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s    <= 1'b0;
      r_last <= 1'b1;
    end else if (w_nxt == OWN0) begin
      r_s    <= 1'b0;
      r_last <= 1'b0;
    end else if (w_nxt == OWN1) begin
      r_s    <= 1'b1;
      r_last <= 1'b1;
    end
  end

  assign w_gnt0   = (r_state == OWN0);
  assign w_gnt1   = (r_state == OWN1);
  assign bus.gnt0 = w_gnt0;
  assign bus.gnt1 = w_gnt1;
  assign bus.busy = w_gnt0 | w_gnt1;
  assign bus.s    = r_s;

endmodule

// File: doc/mux21_arb.md
# mux21_arb

Two-requester round-robin arbiter that owns the select line of the team's 2:1 bit multiplexer. It grants the shared mux path to one requester at a time, drives the select so the granted requester's input reaches the output, and enforces fairness between contending requesters. It sits directly in front of the 2:1 mux. Its `s` output connects to the mux select, and requester 0 and requester 1 drive mux inputs `d0` and `d1`.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive grant cycles while the other requester waits. Legal range is 1 to 255.
- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `req0` input, 1 bit: requester 0 wants the mux path (routes `d0`).
- `req1` input, 1 bit: requester 1 wants the mux path (routes `d1`).
- `gnt0` output, 1 bit: requester 0 owns the path.
- `gnt1` output, 1 bit: requester 1 owns the path.
- `s` output, 1 bit: mux select. 0 selects `d0`, 1 selects `d1`.
- `busy` output, 1 bit: asserted whenever either grant is asserted.

## Operation
- FSM states: `IDLE`, `OWN0`, `OWN1`. The FSM state, grants and `s` are all registered.
- Outputs decode from state:
  - `gnt0` = (state == `OWN0`).
  - `gnt1` = (state == `OWN1`).
  - `busy` = `gnt0` | `gnt1`.
- `s` is a separate register:
  - Loaded with the new owner's index on every grant.
  - Held unchanged in `IDLE`, so the mux output does not glitch between owners.
- `last` register: the index of the most recent owner.
- `IDLE` transitions:
  - Only `req0` asserted: go to `OWN0`.
  - Only `req1` asserted: go to `OWN1`.
  - Both asserted: grant the requester ≠ `last`.
  - Neither asserted: stay in `IDLE`.
- `OWNi`, owner drops `reqi`:
  - If `reqj` is asserted, go directly to `OWNj` (zero dead cycles).
  - Otherwise go to `IDLE`.
- `OWNi` with `reqi` still asserted: stay, except on hold-limit expiry (see Configuration).
- Hold counter `hold_cnt`:
  - Width: `HOLD_W` = $clog2(`MAX_HOLD`+1).
  - Cleared on every grant change.
  - Increments each cycle in `OWNx`.
  - Saturates at `MAX_HOLD`; it never wraps.
- `last` updates on entry to `OWN0` (to 0) and `OWN1` (to 1). It does not change in `IDLE`.
- Reset values:
  - state = `IDLE`.
  - `gnt0` = `gnt1` = 0, `busy` = 0.
  - `s` = 0.
  - `last` = 1, so requester 0 wins the first contended arbitration.
  - `hold_cnt` = 0.
- Reset mid-grant: all outputs drop to their reset values immediately (asynchronously). The FSM re-arbitrates from `IDLE` on the first edge after `rst_n` deasserts.

## Timing
- Grant latency is 1 cycle: a request sampled at edge N produces the grant after edge N.
- Release latency is 1 cycle: the grant drops after the edge that samples the request low.
- On a handover, `gnt` and `s` switch on the same edge, with no overlap cycle.
- `gnt0` & `gnt1` is never 1.
- A requester keeps `reqi` high until it sees `gnti`. An early drop simply withdraws the request with no side effects.
- Simultaneous events in `OWNi`:
  - Owner drops `reqi` in the same cycle the limit expires: the drop rule applies, and the result is identical either way.

## Configuration
- Macro `MUX21_ARB_HOLD_LIMIT_EN` defined:
  - In `OWNi` with `hold_cnt` == `MAX_HOLD`-1 and `reqj` asserted, the next edge preempts to `OWNj` even if `reqi` is still high.
  - If `reqj` is low at expiry, the owner keeps the grant and the counter saturates.
  - Once the counter has saturated, a later `reqj` preempts on its first sampled edge.
- Macro undefined:
  - No preemption; the owner holds as long as `reqi` is high.
  - The `hold_cnt` logic is compiled out.
  - The `MAX_HOLD` parameter is ignored.

## Structure
- Package `mux21_arb_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t`.
  - Constant `ARB_REQ_N` = 2.
  - Function `hold_w(max_hold)`, returning the counter width.
- One sub-module: `mux21_hold_cnt`.
  - Parameterised by `MAX_HOLD`.
  - Inputs: `clk`, `rst_n`, `clr`, `en`.
  - Outputs: `expire` and saturating `cnt`.
  - Instantiated only under `MUX21_ARB_HOLD_LIMIT_EN`.
- The top level contains the FSM, the `last` pointer and the `s` register.

## Test plan
- Reset check: assert `rst_n`=0 with `req0`=`req1`=1 → `gnt0`=`gnt1`=`busy`=`s`=0. Deassert reset → after 1 edge, `gnt0`=1 and `s`=0.
- Single requester: `req1`=1 for 6 cycles, then 0 → `gnt1`=1 from cycle 1 to cycle 6 and `s`=1 throughout, including after release while in `IDLE`. `busy` drops 1 cycle after `req1` falls.
- Round-robin: both requesters hold for one grant each and release alternately → grants alternate 0,1,0,1 with zero dead cycles between owners.
- Hold limit, macro on, `MAX_HOLD`=4: `req0` held and `req1` raised at cycle 1 → `gnt0` for exactly 4 cycles, then `gnt1`, with `s` switching 0→1 on the same edge.
- Hold limit, macro off: same stimulus → `gnt0` stays high until `req0` drops. `gnt1` is asserted on the following edge.
- Mid-grant reset: pulse `rst_n` low for half a cycle while `OWN1` → `gnt1`, `s` and `busy` fall immediately. After reset, contention grants requester 0 first.
